branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped, tag-checked branch history table of 2-bit saturating counters.
- Guess port: fetch looks up a PC and gets hit/taken.
- Check port: execute reports resolved branch outcomes, which allocate or train entries.
- Directly upstream/downstream of the saturating up/down counter: reads stored counter state for prediction and writes back the next counter value.

Parameters:
- PC_WIDTH, 32, width of instruction address.
- LINES, 128, number of table entries; power of two, ≥2.
- IDX_BITS, $clog2(LINES), index width (derived; do not override).
- TAG_BITS, PC_WIDTH-2-IDX_BITS, stored tag width (derived).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pc_guess  in  PC_WIDTH  fetch-stage PC to predict
- is_br_guess  in  1  fetch instruction is a conditional branch
- pc_check  in  PC_WIDTH  PC of resolved branch
- is_br_check  in  1  resolved instruction is a conditional branch (update enable)
- br_taken_check  in  1  resolved outcome, 1 = taken
- br_pred_hit  out  1  table hit for pc_guess (combinational)
- br_pred_taken  out  1  predicted taken (combinational)

Behaviour:
- PC slicing: index = pc[IDX_BITS+1:2]; tag = pc[PC_WIDTH-1:IDX_BITS+2]; pc[1:0] ignored.
- Entry = {valid, tag[TAG_BITS], ctr[2]}.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = ctr[1].
- Guess, asynchronous read, 0-cycle latency:
  - br_pred_hit = is_br_guess & valid[idx] & (tag[idx]==tag(pc_guess)).
  - br_pred_taken = br_pred_hit & ctr[idx][1].
  - Both outputs 0 whenever is_br_guess=0 or on a miss.
- Check, applied at the rising edge when is_br_check=1 and rst=0:
  - Hit (valid & tag match): ctr ← taken ? min(ctr+1, 11) : max(ctr-1, 00). Saturation is mandatory: no wrap 11→00 or 00→11.
  - Miss (invalid or tag mismatch): allocate/replace. valid←1, tag←tag(pc_check), ctr ← taken ? 10 : 01.
  - is_br_check=0: no state change.
- Same-cycle guess/check, same index: guess returns the pre-edge contents. The update becomes visible to guess from the next cycle. No bypass.
- Same-cycle guess/check, different index: independent.
- Reset:
  - rst=1 at an edge clears all valid bits. Tags/counters are don't-care.
  - Any check presented in the same cycle as rst is dropped.
  - From the cycle after reset: every guess misses, so br_pred_hit=0 and br_pred_taken=0.
- Reset mid-operation: identical to power-on reset; all learned state is lost.
- Aliasing: PCs differing only in tag bits evict each other. Replacement re-initialises the counter; no history is carried over.
- Storage: flop or LUTRAM. Valid bits must be flops so reset clears them in one cycle.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs num_checks[31:0] and num_correct[31:0], both reset to 0.
  - num_checks increments on every accepted check (is_br_check & !rst).
  - num_correct increments when the check hits AND the pre-update ctr[1]==br_taken_check.
  - A miss counts as a check but never as correct.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then guess pc=0x0000_1000 with is_br_guess=1 → hit=0, taken=0.
- Check pc=0x1000, taken=1; next cycle guess 0x1000 → hit=1, taken=1 (ctr=10). Check not-taken once → taken=0 (ctr=01).
- Saturation: on pc=0x1000, 4 taken checks, then 1 not-taken → taken=1 (ctr 11→10). 4 not-taken, then 1 taken → taken=0 (ctr 00→01).
- Alias (LINES=128): train 0x1000 to 11, then check 0x1200 (same index, different tag) not-taken.
  - Guess 0x1000 → hit=0.
  - Guess 0x1200 → hit=1, taken=0.
- Same-cycle: entry at 01; guess and check-taken on the same PC in one cycle → guess reports taken=0 that cycle, taken=1 the next cycle.
- Assert rst while is_br_check=1 on a trained PC → afterwards hit=0 for all PCs. With BP_STATS_EN: num_checks=0, num_correct=0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch (guess) and execute (check) signal bundle for branch_predictor.
// With BP_STATS_EN defined, the predictor also reports check/correct counts.
interface branch_predictor_if #(
   parameter int PC_WIDTH = 32
);
   logic [PC_WIDTH-1:0] pc_guess;
   logic                is_br_guess;
   logic [PC_WIDTH-1:0] pc_check;
   logic                is_br_check;
   logic                br_taken_check;
   logic                br_pred_hit;
   logic                br_pred_taken;
`ifdef BP_STATS_EN
   logic [31:0]         num_checks;
   logic [31:0]         num_correct;

   modport master (
      output pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check,
      input  br_pred_hit, br_pred_taken, num_checks, num_correct
   );
   modport slave (
      input  pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check,
      output br_pred_hit, br_pred_taken, num_checks, num_correct
   );
`else
   modport master (
      output pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check,
      input  br_pred_hit, br_pred_taken
   );
   modport slave (
      input  pc_guess, is_br_guess, pc_check, is_br_check, br_taken_check,
      output br_pred_hit, br_pred_taken
   );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped, tag-checked table of 2-bit saturating counters.
// Optional macro BP_STATS_EN adds num_checks/num_correct statistics counters.
module branch_predictor #(
   parameter  int PC_WIDTH = 32,
   parameter  int LINES    = 128,
   localparam int IDX_BITS = $clog2(LINES),
   localparam int TAG_BITS = PC_WIDTH - 2 - IDX_BITS
) (
   input  logic             clk,
   input  logic             rst,
   branch_predictor_if.slave bp
);
   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [1:0]          ctr_q [LINES];

   logic [IDX_BITS-1:0] guess_idx;
   logic [TAG_BITS-1:0] guess_tag;
   logic [IDX_BITS-1:0] check_idx;
   logic [TAG_BITS-1:0] check_tag;
   logic                guess_hit;
   logic                check_hit;
   logic                check_en;
   logic [1:0]          check_ctr;
   logic [1:0]          ctr_next;
   logic [3:0]          unused_pc_bits;

   assign guess_idx      = bp.pc_guess[IDX_BITS+1:2];
   assign guess_tag      = bp.pc_guess[PC_WIDTH-1:IDX_BITS+2];
   assign check_idx      = bp.pc_check[IDX_BITS+1:2];
   assign check_tag      = bp.pc_check[PC_WIDTH-1:IDX_BITS+2];
   assign unused_pc_bits = {bp.pc_guess[1:0], bp.pc_check[1:0]};

   assign guess_hit        = bp.is_br_guess & valid_q[guess_idx] & (tag_q[guess_idx] == guess_tag);
   assign bp.br_pred_hit   = guess_hit;
   assign bp.br_pred_taken = guess_hit & ctr_q[guess_idx][1];

   assign check_en  = bp.is_br_check & ~rst;
   assign check_hit = valid_q[check_idx] & (tag_q[check_idx] == check_tag);
   assign check_ctr = ctr_q[check_idx];

   // Hits saturate toward the outcome; misses restart at the weak state of the outcome
   always_comb begin
      ctr_next = check_ctr;
      if (check_hit) begin
         if (bp.br_taken_check) begin
            if (check_ctr != 2'b11) ctr_next = check_ctr + 2'd1;
         end else begin
            if (check_ctr != 2'b00) ctr_next = check_ctr - 2'd1;
         end
      end else begin
         ctr_next = bp.br_taken_check ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (check_en) begin
         valid_q[check_idx] <= 1'b1;
      end
   end

   // Tags and counters need no reset; an entry is meaningless until its valid bit sets
   always_ff @(posedge clk) begin
      if (check_en) begin
         tag_q[check_idx] <= check_tag;
         ctr_q[check_idx] <= ctr_next;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] num_checks_q;
   logic [31:0] num_correct_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         num_checks_q  <= '0;
         num_correct_q <= '0;
      end else if (check_en) begin
         num_checks_q <= num_checks_q + 32'd1;
         if (check_hit && (check_ctr[1] == bp.br_taken_check))
            num_correct_q <= num_correct_q + 32'd1;
      end
   end

   assign bp.num_checks  = num_checks_q;
   assign bp.num_correct = num_correct_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus queues expectations,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_branch_predictor;
   logic clk;
   logic rst;
   logic obs;
   int   compared;
   int   failed;

   typedef struct {
      logic        hit;
      logic        taken;
      logic        stats;
      logic [31:0] nchk;
      logic [31:0] ncor;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   branch_predictor_if #(.PC_WIDTH(32)) bp_if ();

   branch_predictor #(.PC_WIDTH(32), .LINES(128)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // One cycle of stimulus; when ob is set the expected response is queued for the monitor
   task automatic applyStimulus(input logic ob, input logic ge, input logic [31:0] gpc,
                                input logic ce, input logic [31:0] cpc, input logic tk,
                                input logic r, input logic eh, input logic et,
                                input logic es, input logic [31:0] enc,
                                input logic [31:0] encor, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst                   = r;
      bp_if.is_br_guess     = ge;
      bp_if.pc_guess        = gpc;
      bp_if.is_br_check     = ce;
      bp_if.pc_check        = cpc;
      bp_if.br_taken_check  = tk;
      obs                   = ob;
      if (ob) begin
         e.hit   = eh;
         e.taken = et;
         e.stats = es;
         e.nchk  = enc;
         e.ncor  = encor;
         e.name  = nm;
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (obs) begin
         if (exp_q.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL scoreboard_underflow: got output with no expectation queued");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput({e.name, "_hit"},   {31'd0, bp_if.br_pred_hit},   {31'd0, e.hit});
            checkOutput({e.name, "_taken"}, {31'd0, bp_if.br_pred_taken}, {31'd0, e.taken});
`ifdef BP_STATS_EN
            if (e.stats) begin
               checkOutput({e.name, "_num_checks"},  bp_if.num_checks,  e.nchk);
               checkOutput({e.name, "_num_correct"}, bp_if.num_correct, e.ncor);
            end
`endif
         end
      end
   end

   localparam logic [31:0] PA = 32'h0000_1000;
   localparam logic [31:0] PB = 32'h0000_1200;

   initial begin
      compared = 0;
      failed   = 0;
      obs      = 1'b0;
      rst      = 1'b1;
      bp_if.is_br_guess    = 1'b0;
      bp_if.pc_guess       = '0;
      bp_if.is_br_check    = 1'b0;
      bp_if.pc_check       = '0;
      bp_if.br_taken_check = 1'b0;

      applyStimulus(0, 0, 0,  0, 0,  0, 1, 0, 0, 0, 0, 0, "rst");
      applyStimulus(0, 0, 0,  0, 0,  0, 1, 0, 0, 0, 0, 0, "rst");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 0, 0, 1, 0, 0, "reset_miss");
      // Allocate taken -> 10, then one not-taken -> 01
      applyStimulus(0, 0, 0,  1, PA, 1, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 1, 1, 0, 0, 0, "alloc_taken");
      applyStimulus(0, 0, 0,  1, PA, 0, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 1, 0, 0, 0, 0, "train_nt");
      // Upper saturation: concurrent guesses see pre-edge counter 01,10,11,11,11
      applyStimulus(1, 1, PA, 1, PA, 1, 0, 1, 0, 0, 0, 0, "sat_up0");
      applyStimulus(1, 1, PA, 1, PA, 1, 0, 1, 1, 0, 0, 0, "sat_up1");
      applyStimulus(1, 1, PA, 1, PA, 1, 0, 1, 1, 0, 0, 0, "sat_up2");
      applyStimulus(1, 1, PA, 1, PA, 1, 0, 1, 1, 0, 0, 0, "sat_up3");
      applyStimulus(1, 1, PA, 1, PA, 0, 0, 1, 1, 0, 0, 0, "sat_up4");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 1, 1, 0, 0, 0, "sat_high");
      // Lower saturation: pre-edge counter 10,01,00,00 then taken from 00
      applyStimulus(1, 1, PA, 1, PA, 0, 0, 1, 1, 0, 0, 0, "sat_dn0");
      applyStimulus(1, 1, PA, 1, PA, 0, 0, 1, 0, 0, 0, 0, "sat_dn1");
      applyStimulus(1, 1, PA, 1, PA, 0, 0, 1, 0, 0, 0, 0, "sat_dn2");
      applyStimulus(1, 1, PA, 1, PA, 0, 0, 1, 0, 0, 0, 0, "sat_dn3");
      applyStimulus(1, 1, PA, 1, PA, 1, 0, 1, 0, 0, 0, 0, "sat_dn4");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 1, 0, 0, 0, 0, "sat_low");
      // Alias: train PA to 11, then PB (same index) evicts it
      applyStimulus(0, 0, 0,  1, PA, 1, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(0, 0, 0,  1, PA, 1, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 1, PA, 1, PB, 0, 0, 1, 1, 0, 0, 0, "alias_pre");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 0, 0, 0, 0, 0, "alias_evict");
      applyStimulus(1, 1, PB, 0, 0,  0, 0, 1, 0, 0, 0, 0, "alias_new");
      applyStimulus(1, 1, 32'h0000_1004, 0, 0, 0, 0, 0, 0, 0, 0, 0, "other_idx");
      applyStimulus(1, 1, 32'h0000_1202, 0, 0, 0, 0, 1, 0, 0, 0, 0, "pc_lowbits");
      applyStimulus(1, 0, PB, 0, 0,  0, 0, 0, 0, 0, 0, 0, "guess_disabled");
      // Same-cycle guess/check on PB (ctr 01): no bypass
      applyStimulus(1, 1, PB, 1, PB, 1, 0, 1, 0, 0, 0, 0, "same_cycle_pre");
      applyStimulus(1, 1, PB, 0, 0,  0, 0, 1, 1, 0, 0, 0, "same_cycle_post");
      // is_br_check=0 must not move the counter
      applyStimulus(0, 0, 0,  0, PB, 0, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 1, PB, 0, 0,  0, 0, 1, 1, 0, 0, 0, "no_check_hold");
      // Reset with a concurrent check on a trained PC
      applyStimulus(0, 0, 0,  1, PB, 0, 1, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 1, PB, 0, 0,  0, 0, 0, 0, 1, 0, 0, "midreset_b");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 0, 0, 1, 0, 0, "midreset_a");
      // Miss then correct hit: checks=2, correct=1
      applyStimulus(0, 0, 0,  1, PA, 1, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(0, 0, 0,  1, PA, 1, 0, 0, 0, 0, 0, 0, "");
      applyStimulus(1, 1, PA, 0, 0,  0, 0, 1, 1, 1, 2, 1, "post_reset_train");
      applyStimulus(0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, "");

      @(posedge clk);
      @(posedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
